nand_op_scheduler: RTL and testbench
====================================

NAND_OP_SCHEDULER -- requirements
Module: nand_op_scheduler

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters; fixed at 4 in this revision.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester request; bit i = requester i.
REQ-005 op  input  12  3-bit opcode per requester; requester i at bits [3i+2:3i].
REQ-006 a  input  4  operand A per requester; bit i.
REQ-007 b  input  4  operand B per requester; bit i.
REQ-008 grant  output  4  one-hot owner of the shared NAND unit; all-zero when idle.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 done_id  output  2  index of the requester whose result is on y; valid with done.
REQ-012 y  output  1  result bit; holds its last value until the next done.
REQ-013 err  output  1  high with done when the opcode was reserved.

Function
REQ-014 The block shall own exactly one 2-input NAND evaluation per cycle; every operation is built from sequential NAND steps through it.
REQ-015 Opcodes and step counts: 000 NAND 1; 001 NOT(a) 1; 010 AND 2; 011 OR 3; 100 NOR 4; 101 XOR 4; 110 XNOR 5; 111 reserved 1.
REQ-016 Step sequences (t,u,v are internal temps):
- AND: t=nand(a,b); y=nand(t,t).
- OR: t=nand(a,a); u=nand(b,b); y=nand(t,u).
- NOR: OR sequence, then y=nand(y,y).
- XOR: t=nand(a,b); u=nand(a,t); v=nand(b,t); y=nand(u,v).
- XNOR: XOR sequence, then y=nand(y,y).
REQ-017 Reserved opcode: y shall be 0 and err shall be 1 on its done.
REQ-018 FSM states: IDLE, EXEC, DONE.
- IDLE->EXEC when any req bit is high at a clock edge: grant, opcode and operands registered on that edge.
- EXEC->DONE when the step counter reaches the opcode step count.
- DONE->IDLE unconditionally after one cycle.
REQ-019 Latency: for an opcode with S steps, done shall assert exactly S+1 cycles after the grant edge; it shall not assert in any other cycle.
REQ-020 Arbitration shall be round-robin: the search starts at (last winner+1) mod 4; the pointer resets to 3, so requester 0 has first priority after reset.
REQ-021 grant shall remain stable from the grant edge through the DONE cycle.
REQ-022 Operands and opcode shall be sampled only on the grant edge; later changes on op, a or b shall be ignored.
REQ-023 Deasserting req while the operation is in progress shall not abort it; done is still produced.
REQ-024 A requester whose req is still high in IDLE after its own done shall be treated as a new request.
REQ-025 New requests shall not be accepted in EXEC or DONE.
- The earliest next grant is the IDLE cycle following DONE.
- Throughput is 1 operation per S+2 cycles.
REQ-026 Simultaneous requests: exactly one grant per arbitration; the others stay pending and are not lost as long as req is held.

Reset
REQ-027 While rst is high, state shall be IDLE, the RR pointer 3, and grant, busy, done, done_id, y, err and the temps all 0, independent of clk.
REQ-028 An rst assertion mid-EXEC shall abandon the operation with no done; operation resumes on the first clk edge after rst deasserts.

Structure
REQ-029 A shared package shall hold the opcode constants, the per-opcode step-count table, the FSM state encoding and NREQ.
REQ-030 Round-robin selection shall be a sub-module rr_arbiter_4 (inputs: req, pointer; outputs: one-hot grant, index). The NAND step logic shall stay inline.

Verification
REQ-031 AND: req=0001, op0=010, a0=1, b0=1 -> grant=0001; done 3 cycles after grant; y=1, done_id=0, err=0.
REQ-032 XOR exhaustive: requester 2, opcode 101, operand pairs 00/01/10/11 -> y=0,1,1,0; each done 5 cycles after its grant.
REQ-033 Round-robin: req=1111 held, all opcode NAND -> grants 0001,0010,0100,1000,0001; done_id=0,1,2,3,0; operations 3 cycles apart.
REQ-034 Mid-op changes: OR granted with a=0, b=0; a flipped to 1 and req dropped during EXEC -> done still produced, y=0.
REQ-035 Reset in EXEC: XNOR granted, rst pulsed at cycle 2 -> no done; all outputs 0; next req=0001 granted normally.
REQ-036 Reserved opcode: op=111 -> done after 2 cycles, y=0, err=1; a following NOT with a=0 -> y=1, err=0.

Source files
------------

// File: rtl/nand_op_scheduler_pkg.sv
// Shared definitions for the NAND operation scheduler: requester count,
// opcodes, per-opcode NAND step counts, FSM states and step destinations.
package nand_op_scheduler_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic [2:0] {
    OP_NAND = 3'b000,
    OP_NOT  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_NOR  = 3'b100,
    OP_XOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_RSVD = 3'b111
  } opcode_e;

  // Number of NAND steps per opcode, indexed by opcode value.
  localparam logic [7:0][2:0] STEP_TABLE = {
    3'd1,  // reserved
    3'd5,  // XNOR
    3'd4,  // XOR
    3'd4,  // NOR
    3'd3,  // OR
    3'd2,  // AND
    3'd1,  // NOT
    3'd1   // NAND
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // Where the result of the current NAND step is written.
  typedef enum logic [2:0] {
    DST_T,
    DST_U,
    DST_V,
    DST_R,
    DST_ZERO
  } dst_e;

  function automatic logic [2:0] step_count(input opcode_e o);
    return STEP_TABLE[o];
  endfunction

endpackage

// File: rtl/nand_op_scheduler_rr_arbiter_4.sv
// Four-way round-robin selector: search begins one past the last winner.
module rr_arbiter_4
  import nand_op_scheduler_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      pointer,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      index
);

  logic       found;
  logic [1:0] cand;

  // Walk requesters from pointer+1 around to pointer; first active one wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = pointer + k[1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/nand_op_scheduler.sv
// Shared single-NAND execution unit: arbitrates among requesters and builds
// each logic operation from a sequence of one NAND evaluation per cycle.
module nand_op_scheduler #(
  parameter int unsigned NREQ = nand_op_scheduler_pkg::NREQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] op,
  input  logic [NREQ-1:0]   a,
  input  logic [NREQ-1:0]   b,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_id,
  output logic              y,
  output logic              err
);

  import nand_op_scheduler_pkg::*;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      idx_q, idx_d;
  opcode_e         op_q, op_d;
  logic            a_q, a_d, b_q, b_d;
  logic            t_q, t_d, u_q, u_d, v_q, v_d, r_q, r_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      done_id_q, done_id_d;
  logic            y_q, y_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [1:0]      arb_idx;
  logic [2:0]      op_sel;

  logic            nand_x, nand_y, nand_o;
  dst_e            dst;

  rr_arbiter_4 u_arb (
    .req     (req),
    .pointer (ptr_q),
    .grant   (arb_gnt),
    .index   (arb_idx)
  );

  // Select the operands and destination of this cycle's single NAND step.
  always_comb begin
    nand_x = a_q;
    nand_y = b_q;
    dst    = DST_R;
    case (op_q)
      OP_NAND: ;
      OP_NOT:  nand_y = a_q;
      OP_AND: begin
        case (cnt_q)
          3'd0:    dst = DST_T;
          default: begin nand_x = t_q; nand_y = t_q; end
        endcase
      end
      OP_OR, OP_NOR: begin
        case (cnt_q)
          3'd0:    begin nand_y = a_q; dst = DST_T; end
          3'd1:    begin nand_x = b_q; dst = DST_U; end
          3'd2:    begin nand_x = t_q; nand_y = u_q; end
          default: begin nand_x = r_q; nand_y = r_q; end
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (cnt_q)
          3'd0:    dst = DST_T;
          3'd1:    begin nand_y = t_q; dst = DST_U; end
          3'd2:    begin nand_x = b_q; nand_y = t_q; dst = DST_V; end
          3'd3:    begin nand_x = u_q; nand_y = v_q; end
          default: begin nand_x = r_q; nand_y = r_q; end
        endcase
      end
      default: dst = DST_ZERO;
    endcase
    nand_o = ~(nand_x & nand_y);
  end

  // FSM next state, operand capture, step execution and result publication.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    t_d       = t_q;
    u_d       = u_q;
    v_d       = v_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    done_id_d = done_id_q;
    y_d       = y_q;
    op_sel    = op[3*int'(arb_idx) +: 3];

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_EXEC;
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          ptr_d   = arb_idx;
          op_d    = opcode_e'(op_sel);
          a_d     = a[arb_idx];
          b_d     = b[arb_idx];
          cnt_d   = '0;
        end
      end
      ST_EXEC: begin
        case (dst)
          DST_T:   t_d = nand_o;
          DST_U:   u_d = nand_o;
          DST_V:   v_d = nand_o;
          DST_R:   r_d = nand_o;
          default: r_d = 1'b0;
        endcase
        cnt_d = cnt_q + 3'd1;
        if (cnt_d == step_count(op_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Result is published on leaving DONE so done lands S+1 cycles
        // after the grant edge while grant still covers the DONE cycle.
        state_d   = ST_IDLE;
        grant_d   = '0;
        done_d    = 1'b1;
        done_id_d = idx_q;
        y_d       = r_q;
        err_d     = (op_q == OP_RSVD);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= 2'd3;
      idx_q     <= '0;
      op_q      <= OP_NAND;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      t_q       <= 1'b0;
      u_q       <= 1'b0;
      v_q       <= 1'b0;
      r_q       <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      y_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      t_q       <= t_d;
      u_q       <= u_d;
      v_q       <= v_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      y_q       <= y_d;
      err_q     <= err_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign y       = y_q;
  assign err     = err_q;

endmodule

// File: tb/tb_nand_op_scheduler.sv
// Self-checking bench for nand_op_scheduler: directed table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_nand_op_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] op  = '0;
  logic [3:0]  a   = '0;
  logic [3:0]  b   = '0;
  logic [3:0]  grant;
  logic        busy, done, y, err;
  logic [1:0]  done_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_gcyc = 0;
  int ptr_m = 3;

  nand_op_scheduler #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id),
    .y(y), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  rq;
    logic [11:0] opv;
    logic [3:0]  av, bv;
    logic [3:0]  eg;
    logic        ey, ee;
    logic [1:0]  eid;
    int          elat, egap;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one operation from IDLE and follow it to its done pulse.
  task automatic exec_op(input logic [3:0] rq, input logic [11:0] opv,
                         input logic [3:0] av, input logic [3:0] bv, input bit pert,
                         input logic [3:0] eg, input logic ey, input logic ee,
                         input logic [1:0] eid, input int elat, input int egap);
    int  gcyc;
    bit  seen;
    @(negedge clk);
    req = rq; op = opv; a = av; b = bv;
    @(posedge clk); #1;
    chk("grant", grant, eg);
    chk("busy_at_grant", busy, 1);
    chk("done_at_grant", done, 0);
    gcyc = cyc;
    if (egap > 0) chk("op_gap", gcyc - last_gcyc, egap);
    last_gcyc = gcyc;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      if (pert && k == 0) begin
        @(negedge clk);
        a = ~av; b = ~bv; op = ~opv; req = '0;
      end
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      else chk("grant_hold", grant, eg);
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done want done within 16 cycles");
    end else begin
      chk("latency", cyc - gcyc, elat);
      chk("y", y, ey);
      chk("err", err, ee);
      chk("done_id", done_id, eid);
      chk("grant_after", grant, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  function automatic logic ref_y(input int code, input logic x, input logic z);
    case (code)
      0: return ~(x & z);
      1: return ~x;
      2: return x & z;
      3: return x | z;
      4: return ~(x | z);
      5: return x ^ z;
      6: return ~(x ^ z);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_steps(input int code);
    case (code)
      0, 1, 7: return 1;
      2: return 2;
      3: return 3;
      4, 5: return 4;
      default: return 5;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin under req=1111, all NAND; a=0101, b=0011.
    tbl[0]  = '{4'hF, 12'h000, 4'b0101, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd0, 2, 0};
    tbl[1]  = '{4'hF, 12'h000, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 2'd1, 2, 3};
    tbl[2]  = '{4'hF, 12'h000, 4'b0101, 4'b0011, 4'b0100, 1'b1, 1'b0, 2'd2, 2, 3};
    tbl[3]  = '{4'hF, 12'h000, 4'b0101, 4'b0011, 4'b1000, 1'b1, 1'b0, 2'd3, 2, 3};
    tbl[4]  = '{4'hF, 12'h000, 4'b0101, 4'b0011, 4'b0001, 1'b0, 1'b0, 2'd0, 2, 3};
    // AND on requester 0.
    tbl[5]  = '{4'b0001, 12'b000_000_000_010, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 3, 0};
    // XOR exhaustive on requester 2.
    tbl[6]  = '{4'b0100, 12'b000_101_000_000, 4'b1011, 4'b1011, 4'b0100, 1'b0, 1'b0, 2'd2, 5, 0};
    tbl[7]  = '{4'b0100, 12'b000_101_000_000, 4'b1011, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, 5, 0};
    tbl[8]  = '{4'b0100, 12'b000_101_000_000, 4'b0100, 4'b1011, 4'b0100, 1'b1, 1'b0, 2'd2, 5, 0};
    tbl[9]  = '{4'b0100, 12'b000_101_000_000, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd2, 5, 0};
    // Reserved opcode, then NOT with a=0.
    tbl[10] = '{4'b0001, 12'b000_000_000_111, 4'b1111, 4'b1111, 4'b0001, 1'b0, 1'b1, 2'd0, 2, 0};
    tbl[11] = '{4'b0001, 12'b000_000_000_001, 4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 2, 0};

    // Reset values, asynchronous (no clock edge yet).
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_y", y, 0);
    chk("rst_err", err, 0);
    do_reset();

    foreach (tbl[i])
      exec_op(tbl[i].rq, tbl[i].opv, tbl[i].av, tbl[i].bv, 1'b0, tbl[i].eg,
              tbl[i].ey, tbl[i].ee, tbl[i].eid, tbl[i].elat, tbl[i].egap);

    // OR with a=b=0; inputs flipped and req dropped during EXEC.
    exec_op(4'b0001, 12'b011, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4, 0);

    // Put y=1, done_id=2 on the outputs, then reset in the middle of XNOR.
    exec_op(4'b0100, 12'b000_001_000_000, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 2, 0);
    @(negedge clk);
    req = 4'b0001; op = 12'b110; a = '0; b = '0;
    @(posedge clk); #1;
    chk("xnor_grant", grant, 4'b0001);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = '0;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_done_id", done_id, 0);
    chk("midrst_y", y, 0);
    chk("midrst_err", err, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("midrst_hold_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
    end
    exec_op(4'b0001, 12'b000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 2, 0);

    // Randomized traffic against the behavioural model.
    do_reset();
    ptr_m = 3;
    for (int n = 0; n < 80; n++) begin
      logic [3:0]  rq, av, bv, eg;
      logic [11:0] opv;
      int          w, code;
      bit          pert;
      rq   = 4'($urandom_range(1, 15));
      opv  = 12'($urandom);
      av   = 4'($urandom);
      bv   = 4'($urandom);
      pert = ($urandom_range(0, 3) == 0);
      w = 0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (ptr_m + k) % 4;
        if (rq[c]) begin w = c; break; end
      end
      ptr_m = w;
      eg    = 4'(1 << w);
      code  = int'((opv >> (3 * w)) & 12'h7);
      exec_op(rq, opv, av, bv, pert, eg, ref_y(code, av[w], bv[w]),
              (code == 7), 2'(w), ref_steps(code) + 1, 0);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        req = '0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
